// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//
// Stall, flush and termination controller for the 5-stage IF/ID/EX/MEM/WB core.
//   - Load-use hazard between EX (load) and ID: stalls PC and IF/ID for one
//     cycle and bubbles ID/EX. The next cycle evaluates the hazard again.
//   - Taken branch resolved in EX: squashes the two wrong-path instructions in
//     IF and ID.
//   - All-zero instruction word in IF (halt): stops fetch, lets the older
//     instructions drain for DRAIN_CYCLES cycles, then raises end_program.
//
// Optional build macro: PIPE_PERF_EN adds saturating cycle/stall/flush
// counters. Without it those ports and their logic are absent.
//
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN before end_program (1..15)
//   CNT_W         performance counter width (PIPE_PERF_EN only)
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   if_instr         instruction word currently in IF
//   id_rs1, id_rs2   source registers of the instruction in ID
//   id_uses_rs2      ID instruction actually reads rs2
//   ex_mem_read      EX instruction is a load
//   ex_rd            destination register of the EX instruction
//   ex_branch_taken  branch in EX resolved taken this cycle
//   pc_write         PC may update this cycle
//   if_id_write      IF/ID register may load
//   if_id_flush      IF/ID loads a NOP
//   id_ex_bubble     ID/EX loads a bubble (control zeroed)
//   halting          controller is draining or done
//   end_program      registered, sticky until reset
//   cycle_count, stall_count, flush_count  (PIPE_PERF_EN only)
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        halting,
  output logic        end_program
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter holds the number of DRAIN cycles still to follow the current one.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] drain_cnt_reg, drain_cnt_next;
  logic       end_program_reg, end_program_next;

  logic load_use;
  logic halt_seen;

  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign halt_seen = (if_instr == 32'h0);

  assign halting     = (state_reg != ST_RUN);
  assign end_program = end_program_reg;

  always_comb begin
    state_next       = state_reg;
    drain_cnt_next   = drain_cnt_reg;
    end_program_next = end_program_reg;
    // Safe values: freeze fetch, feed NOPs and bubbles.
    pc_write         = 1'b0;
    if_id_write      = 1'b0;
    if_id_flush      = 1'b1;
    id_ex_bubble     = 1'b1;

    if (!reset) begin
      unique case (state_reg)
        ST_RUN: begin
          if (ex_branch_taken) begin
            // Branch wins over any hazard: the stalled instruction is wrong-path.
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (halt_seen) begin
            // Halt word never enters ID; IF/ID receives a NOP instead.
            pc_write       = 1'b0;
            if_id_write    = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b0;
            state_next     = ST_DRAIN;
            drain_cnt_next = DRAIN_LOAD;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
          end
        end

        ST_DRAIN: begin
          if (ex_branch_taken) begin
            // The halt word was on the wrong path: resume normal execution.
            pc_write       = 1'b1;
            if_id_write    = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            state_next     = ST_RUN;
            drain_cnt_next = 4'd0;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = !load_use;
            if_id_flush  = 1'b1;
            id_ex_bubble = load_use;
            // A stall inside the drain does not count toward the drain time.
            if (!load_use) begin
              if (drain_cnt_reg == 4'd0) begin
                state_next       = ST_DONE;
                end_program_next = 1'b1;
              end else begin
                drain_cnt_next = drain_cnt_reg - 4'd1;
              end
            end
          end
        end

        ST_DONE: begin
          // Outputs stay at the safe defaults; inputs are ignored.
        end

        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      drain_cnt_reg   <= 4'd0;
      end_program_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      drain_cnt_reg   <= drain_cnt_next;
      end_program_reg <= end_program_next;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_reg, stall_cnt_reg, flush_cnt_reg;
  logic             active;

  assign active = (state_reg != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_reg <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (active) begin
      if (!(&cycle_cnt_reg)) begin
        cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      end
      if (load_use && !ex_branch_taken && !(&stall_cnt_reg)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (ex_branch_taken && !(&flush_cnt_reg)) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign cycle_count = cycle_cnt_reg;
  assign stall_count = stall_cnt_reg;
  assign flush_count = flush_cnt_reg;
`endif

endmodule
